// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame geometry.
package uart_rx_pkg;

   localparam int OVS_DEF     = 16;
   localparam int NB_DATA_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-facing bundle: oversampling tick and serial line in, recovered word and flags out.
interface uart_rx_if
   import uart_rx_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF
);

   logic               tick;
   logic               rx;
   logic [NB_DATA-1:0] dout;
   logic               rx_done;
   logic               frame_err;
   logic               parity_err;

   modport master (
      output tick, rx,
      input  dout, rx_done, frame_err, parity_err
   );

   modport slave (
      input  tick, rx,
      output dout, rx_done, frame_err, parity_err
   );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit with a selectable reset value.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: samples each bit mid-period and reports the word with error flags.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int NB_DATA    = NB_DATA_DEF,
   parameter int SB_TICK    = 16,
   parameter int OVS        = OVS_DEF,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic      i_clk,
   input  logic      i_reset,
   uart_rx_if.slave  bus
);

   localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
   localparam int S_W   = $clog2(S_MAX);
   localparam int N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

   localparam logic [S_W-1:0] S_MID     = S_W'(OVS / 2 - 1);
   localparam logic [S_W-1:0] S_LAST    = S_W'(OVS - 1);
   localparam logic [S_W-1:0] S_STOP    = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST    = N_W'(NB_DATA - 1);
   localparam logic           ODD       = 1'(PARITY_ODD);
   localparam state_t         AFTER_DAT = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;

   state_t             state;
   logic [S_W-1:0]     s;
   logic [N_W-1:0]     n;
   logic [NB_DATA-1:0] b;
   logic               perr;
   logic               rx_s;
   logic [NB_DATA-1:0] dout_r;
   logic               done_r;
   logic               ferr_r;
   logic               perr_r;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .d       (bus.rx),
      .q       (rx_s)
   );

   // IDLE reacts to the line without waiting for a tick; every other state only counts ticks.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state  <= ST_IDLE;
         s      <= '0;
         n      <= '0;
         b      <= '0;
         perr   <= 1'b0;
         dout_r <= '0;
         done_r <= 1'b0;
         ferr_r <= 1'b0;
         perr_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state <= ST_START;
                  s     <= '0;
               end
            end
            ST_START: begin
               if (bus.tick) begin
                  if (s == S_MID) begin
                     s <= '0;
                     if (!rx_s) begin
                        state <= ST_DATA;
                        n     <= '0;
                        perr  <= 1'b0;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (bus.tick) begin
                  if (s == S_LAST) begin
                     s <= '0;
                     b <= {rx_s, b[NB_DATA-1:1]};
                     if (n == N_LAST) begin
                        state <= AFTER_DAT;
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (bus.tick) begin
                  if (s == S_LAST) begin
                     s     <= '0;
                     perr  <= (^b) ^ rx_s ^ ODD;
                     state <= ST_STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            // A low stop sample parks in BREAK so a held-low line cannot start a new frame.
            ST_STOP: begin
               if (bus.tick) begin
                  if (s == S_STOP) begin
                     s      <= '0;
                     dout_r <= b;
                     ferr_r <= ~rx_s;
                     perr_r <= perr;
                     done_r <= 1'b1;
                     state  <= rx_s ? ST_IDLE : ST_BREAK;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.dout       = dout_r;
   assign bus.rx_done    = done_r;
   assign bus.frame_err  = ferr_r;
   assign bus.parity_err = perr_r;

endmodule
